// File: rtl/kf_fxp_pkg.sv
// Shared fixed-point definitions for the 2x2 inverse scheduling slice.
package kf_fxp_pkg;

  localparam int DEF_N    = 20;
  localparam int DEF_FRAC = 10;

  // Element slot within a packed {a,b,c,d} word, in units of N bits.
  localparam int OFS_A = 3;
  localparam int OFS_B = 2;
  localparam int OFS_C = 1;
  localparam int OFS_D = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/inv2_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first valid request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/inv2_rr_scheduler.sv
// Round-robin front end sharing one 2x2 inverse engine among NREQ requesters.
//   state | meaning
//   IDLE  | arbitrate, accept winner and latch its operands
//   ISSUE | one-cycle engine start, clear watchdog
//   WAIT  | hold operands, wait for done or watchdog expiry
//   RESP  | present tagged response until consumed
module inv2_rr_scheduler
  import kf_fxp_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int FRAC    = DEF_FRAC,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*4*N-1:0]   req_abcd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic [N-1:0]          rsp_ia,
  output logic [N-1:0]          rsp_ib,
  output logic [N-1:0]          rsp_ic,
  output logic [N-1:0]          rsp_id_out,
  output logic                  eng_start,
  output logic [N-1:0]          eng_a,
  output logic [N-1:0]          eng_b,
  output logic [N-1:0]          eng_c,
  output logic [N-1:0]          eng_d,
  input  logic                  eng_done,
  input  logic [N-1:0]          eng_ia,
  input  logic [N-1:0]          eng_ib,
  input  logic [N-1:0]          eng_ic,
  input  logic [N-1:0]          eng_id,
  output logic                  busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("IDW must equal clog2(NREQ)");
  end
  if (FRAC >= N) begin : g_bad_frac
    $error("FRAC must be smaller than N");
  end

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4*N-1:0] ops_q, ops_d;
  logic [4*N-1:0] res_q, res_d;
  logic           err_q, err_d;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .id    (arb_id),
    .any   (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          id_d    = arb_id;
          ops_d   = req_abcd[int'(arb_id)*4*N +: 4*N];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (eng_done) begin
          res_d   = {eng_ia, eng_ib, eng_ic, eng_id};
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      ops_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) ? arb_grant : '0;
  assign eng_start  = (state_q == ST_ISSUE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = id_q;
  assign rsp_err    = err_q;
  assign eng_a      = ops_q[OFS_A*N +: N];
  assign eng_b      = ops_q[OFS_B*N +: N];
  assign eng_c      = ops_q[OFS_C*N +: N];
  assign eng_d      = ops_q[OFS_D*N +: N];
  assign rsp_ia     = res_q[OFS_A*N +: N];
  assign rsp_ib     = res_q[OFS_B*N +: N];
  assign rsp_ic     = res_q[OFS_C*N +: N];
  assign rsp_id_out = res_q[OFS_D*N +: N];

endmodule

// File: tb/tb_inv2_rr_scheduler.sv
// Bench for inv2_rr_scheduler: behavioural inverse engine, response scoreboard, grant log.
module tb_inv2_rr_scheduler;

  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*4*N-1:0] req_abcd;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;
  logic [N-1:0]        rsp_ia, rsp_ib, rsp_ic, rsp_id_out;
  logic                eng_start;
  logic [N-1:0]        eng_a, eng_b, eng_c, eng_d;
  logic                eng_done;
  logic [N-1:0]        eng_ia, eng_ib, eng_ic, eng_id;
  logic                busy;

  inv2_rr_scheduler #(.N(N), .FRAC(FRAC), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_abcd(req_abcd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_ia(rsp_ia), .rsp_ib(rsp_ib), .rsp_ic(rsp_ic), .rsp_id_out(rsp_id_out),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c), .eng_d(eng_d),
    .eng_done(eng_done), .eng_ia(eng_ia), .eng_ib(eng_ib), .eng_ic(eng_ic), .eng_id(eng_id),
    .busy(busy)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic           err;
    logic [4*N-1:0] pay;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] grant;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   grant_log[$];
  exp_t mon_e;

  logic [4*N-1:0] opnd [NREQ];
  assign req_abcd = {opnd[3], opnd[2], opnd[1], opnd[0]};

  int             eng_lat = 4;
  bit             spur_done = 0;
  bit             eng_act = 0;
  bit             eng_stable = 1;
  int             eng_rem = 0;
  logic [4*N-1:0] eng_cap;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [NREQ-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Reference 2x2 inverse: inv = [d -b; -c a] / (ad - bc), all in Q(N-FRAC).FRAC.
  function automatic logic [4*N-1:0] inv_model(input logic [4*N-1:0] v);
    longint a, b, c, d, det, t;
    logic [N-1:0] ra, rb, rc, rd;
    a = $signed(v[4*N-1 -: N]);
    b = $signed(v[3*N-1 -: N]);
    c = $signed(v[2*N-1 -: N]);
    d = $signed(v[N-1 -: N]);
    det = a * d - b * c;
    if (det == 0) return '0;
    t = (d <<< (2 * FRAC)) / det;   ra = t[N-1:0];
    t = (-b <<< (2 * FRAC)) / det;  rb = t[N-1:0];
    t = (-c <<< (2 * FRAC)) / det;  rc = t[N-1:0];
    t = (a <<< (2 * FRAC)) / det;   rd = t[N-1:0];
    return {ra, rb, rc, rd};
  endfunction

  // Engine model: result eng_lat cycles after start (0 = hang), operands must hold meanwhile.
  initial begin
    eng_done = 1'b0;
    {eng_ia, eng_ib, eng_ic, eng_id} = '0;
    forever begin
      @(negedge clk);
      eng_done = spur_done;
      if (rst) begin
        eng_act = 0;
      end else if (eng_act) begin
        if ({eng_a, eng_b, eng_c, eng_d} !== eng_cap) eng_stable = 0;
        if (eng_lat > 0) begin
          eng_rem--;
          if (eng_rem == 0) begin
            eng_done = 1'b1;
            {eng_ia, eng_ib, eng_ic, eng_id} = inv_model(eng_cap);
            eng_act = 0;
            chk("eng_operand_stable", eng_stable, 1);
          end
        end
      end
      if (eng_start && !rst) begin
        eng_act    = 1;
        eng_cap    = {eng_a, eng_b, eng_c, eng_d};
        eng_rem    = eng_lat;
        eng_stable = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual id=%0d required=none", rsp_id);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", rsp_id, mon_e.id);
        chk("rsp_err", rsp_err, mon_e.err);
        chk("rsp_payload", {rsp_ia, rsp_ib, rsp_ic, rsp_id_out}, mon_e.pay);
      end
    end
    if (!rst && req_ready != '0) grant_log.push_back(oh2id(req_ready));
  end

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_exp(input int id, input bit err);
    exp_t e;
    e.id  = IDW'(id);
    e.err = err;
    e.pay = err ? '0 : inv_model(opnd[id]);
    sb.push_back(e);
  endtask

  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] exp_grant,
                         input int rsp_at, input bit exp_err, input string nm);
    int t0, k;
    bit ok;
    push_exp(oh2id(exp_grant), exp_err);
    @(posedge clk); #1 req_valid = mask;
    ok = 0; k = 0;
    while (!ok && k < 20) begin @(negedge clk); k++; if (req_ready != '0) ok = 1; end
    chk({nm, "_grant"}, req_ready, exp_grant);
    t0 = cyc;
    @(posedge clk); #1 req_valid = '0;
    ok = 0; k = 0;
    while (!ok && k < 10) begin @(negedge clk); k++; if (eng_start) ok = 1; end
    chk({nm, "_start_cyc"}, ok ? cyc - t0 : -1, 1);
    ok = 0; k = 0;
    while (!ok && k < 40) begin @(negedge clk); k++; if (rsp_valid) ok = 1; end
    chk({nm, "_rsp_cyc"}, ok ? cyc - t0 : -1, rsp_at);
    ok = 0; k = 0;
    while (!ok && k < 40) begin @(negedge clk); k++; if (!busy && !rsp_valid) ok = 1; end
    chk({nm, "_idle"}, ok, 1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [IDW-1:0] snap_id;
    logic [4*N-1:0] snap_pay;
    bit ok, stable;
    int k;

    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    opnd[0] = {20'sd1024, 20'sd0,    20'sd0,    20'sd1024};
    opnd[1] = {20'sd1024, 20'sd512,  20'sd0,    20'sd2048};
    opnd[2] = {20'sd2048, 20'sd0,    20'sd0,    20'sd4096};
    opnd[3] = {20'sd3072, 20'sd1024, 20'sd1024, 20'sd3072};

    // Pointer walk from reset: 0 -> 3 -> 0 -> 2 -> 1 -> 3 -> 1
    vecs[0] = '{4'b0100, 4'b0100};
    vecs[1] = '{4'b1011, 4'b1000};
    vecs[2] = '{4'b0110, 4'b0010};
    vecs[3] = '{4'b0011, 4'b0001};
    vecs[4] = '{4'b1101, 4'b0100};
    vecs[5] = '{4'b0001, 4'b0001};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, eng_start, busy}, '0);
    chk("rst_rsp_payload", {rsp_ia, rsp_ib, rsp_ic, rsp_id_out}, '0);
    chk("rst_eng_ops", {eng_a, eng_b, eng_c, eng_d}, '0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].mask, vecs[v].grant, 6, 0, $sformatf("vec%0d", v));
      if (v == 0) begin
        chk("single_ia", rsp_ia, 20'd512);
        chk("single_ib_ic", {rsp_ib, rsp_ic}, '0);
        chk("single_id", rsp_id_out, 20'd256);
        chk("single_tag", {rsp_id, rsp_err}, {2'd2, 1'b0});
      end
    end

    // Backpressure: pointer 1, request 1 wins, consumer stalls 10 cycles.
    rsp_ready = 1'b0;
    push_exp(1, 0);
    @(posedge clk); #1 req_valid = 4'b0010;
    ok = 0; k = 0;
    while (!ok && k < 20) begin @(negedge clk); k++; if (req_ready != '0) ok = 1; end
    chk("bp_grant", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    ok = 0; k = 0;
    while (!ok && k < 40) begin @(negedge clk); k++; if (rsp_valid) ok = 1; end
    chk("bp_rsp_seen", ok, 1);
    snap_id  = rsp_id;
    snap_pay = {rsp_ia, rsp_ib, rsp_ic, rsp_id_out};
    @(posedge clk); #1 req_valid = 4'b1111;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_id !== snap_id || {rsp_ia, rsp_ib, rsp_ic, rsp_id_out} !== snap_pay ||
          req_ready != '0 || !busy) stable = 0;
    end
    chk("bp_hold", stable, 1);
    chk("bp_held_id", snap_id, 2'd1);
    @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_accept", rsp_valid, 1);
    @(negedge clk);
    chk("bp_consumed", {sb.size() == 0, rsp_valid, busy}, 3'b100);

    // Hung engine: pointer 2, request 3 wins, 15 WAIT cycles then error.
    eng_lat = 0;
    run_txn(4'b1000, 4'b1000, 17, 1, "hang");
    eng_lat = 4;
    run_txn(4'b0001, 4'b0001, 6, 0, "after_hang");

    // Done on the 15th WAIT cycle beats the watchdog.
    eng_lat = 15;
    run_txn(4'b0010, 4'b0010, 17, 0, "done_at_limit");
    eng_lat = 4;

    // Spurious done while idle.
    @(posedge clk); #1 spur_done = 1;
    @(posedge clk); #1 spur_done = 0;
    repeat (2) @(negedge clk);
    chk("spurious_done_idle", {busy, rsp_valid}, 2'b00);

    // Reset during WAIT: in-flight request dropped, pointer back to 0.
    run_txn(4'b0100, 4'b0100, 6, 0, "pre_rst");
    @(posedge clk); #1 req_valid = 4'b0100;
    ok = 0; k = 0;
    while (!ok && k < 20) begin @(negedge clk); k++; if (req_ready != '0) ok = 1; end
    chk("inflight_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(negedge clk);
    chk("inflight_in_wait", {busy, eng_start, rsp_valid}, 3'b100);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {busy, rsp_valid, eng_start}, 3'b000);
    run_txn(4'b1001, 4'b0001, 6, 0, "post_rst");

    // Fairness with every requester valid.
    pulse_rst();
    grant_log.delete();
    push_exp(0, 0); push_exp(1, 0); push_exp(2, 0); push_exp(3, 0); push_exp(0, 0);
    @(posedge clk); #1 req_valid = 4'b1111;
    k = 0;
    while (grant_log.size() < 5 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1 req_valid = '0;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("fair_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("fair_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, i % NREQ);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/inv2_rr_scheduler.md
Name: inv2_rr_scheduler

Overview:
Shares one 2x2 fixed-point inverse engine among NREQ requesters, such as per-channel Kalman gain units. The scheduler performs round-robin arbitration and latches the winner's operands. It holds those operands stable for the whole engine run, issues a one-cycle start and captures the four results on done. It then returns the results on a shared response channel tagged with the requester ID. A timeout watchdog turns a hung engine into an error response.

Parameters:
N, 20, operand/result width (signed fixed point)
FRAC, 10, fractional bits (pass-through only; no arithmetic here)
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, must equal ceil(log2(NREQ))
TIMEOUT, 15, WAIT cycles allowed before an error response

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request
req_ready  out  NREQ  one-hot acceptance strobe
req_abcd  in  NREQ*4*N  per requester {a,b,c,d}; a is MSBs; requester i at slice i
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  requester that owns the response
rsp_err  out  1  response is a timeout
rsp_ia, rsp_ib, rsp_ic, rsp_id_out  out  N each  inverse elements
eng_start  out  1  engine start pulse
eng_a, eng_b, eng_c, eng_d  out  N each  engine operands
eng_done  in  1  engine done pulse
eng_ia, eng_ib, eng_ic, eng_id  in  N each  engine results
busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values:
  - State is IDLE; the round-robin pointer is 0.
  - All outputs are 0: req_ready, rsp_*, eng_*, busy.
- The engine's own reset is separate. The integrator must assert it together with rst.
- State IDLE:
  - req_ready is combinational and is the one-hot of the round-robin winner among req_valid.
  - Search starts at pointer and wraps modulo NREQ.
  - If any request is valid, the handshake completes this cycle. Latch that requester's operands into eng_a..d, latch its ID, go to ISSUE.
  - If none is valid, req_ready is 0.
- State ISSUE: eng_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- State WAIT:
  - eng_a..d stay stable. The engine resamples operands for several cycles after start, so they must not change.
  - The counter increments each cycle.
  - On eng_done: latch eng_ia..id into rsp_*, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_* results=0, rsp_err=1, go to RESP.
  - If eng_done coincides with the timeout cycle, eng_done wins.
- State RESP:
  - rsp_valid=1. rsp_id and payload are held stable until rsp_ready=1.
  - On rsp_ready: rsp_valid falls next cycle, pointer=(rsp_id+1) mod NREQ, state goes to IDLE.
  - No request is accepted in RESP. This gives a one-cycle IDLE bubble per transaction.
- Latency with a nominal 4-cycle engine:
  - Acceptance at cycle T, eng_start at T+1, eng_done at T+5.
  - rsp_valid is first high at T+6.
- req_ready is 0 outside IDLE.
- eng_done outside WAIT is ignored; no state change.
- rsp_ready while rsp_valid=0 is ignored.
- A requester that drops req_valid before being granted loses its turn silently. The pointer is unchanged.
- rst mid-operation: the in-flight transaction is discarded and no response is produced. The engine must be reset by the integrator at the same time.
- Fairness: with all requesters continuously valid, grants go 0,1,2,...,NREQ-1,0,...

Decomposition:
- Shared package kf_fxp_pkg gets:
  - state encoding constants IDLE/ISSUE/WAIT/RESP
  - the operand packing offsets (a at 4N-1:3N, b at 3N-1:2N, c at 2N-1:N, d at N-1:0)
  - the default N/FRAC
- One sub-module, rr_arbiter: combinational NREQ-wide round-robin pick that takes the pointer and returns a one-hot grant plus an encoded ID.
- The watchdog counter stays inline.

Test Plan:
- Bench engine model: a behavioural inverse with configurable latency (4 nominal) that checks operand stability between start and done.
- Single request: N=20, FRAC=10. Req 2 with a=2048, b=0, c=0, d=4096.
  - Required: req_ready=0100 at T, eng_start at T+1.
  - Response at T+6: rsp_id=2, ia=512, ib=0, ic=0, id=256, err=0.
- All 4 requesters valid continuously, rsp_ready tied 1, distinct operands each.
  - Required: grant order 0,1,2,3,0.
  - Each rsp_id matches its operands; every accepted request gets exactly one response.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - Required: payload and rsp_id stable throughout, req_ready stays 0, busy=1.
  - Response consumed on the first cycle rsp_ready=1.
- Engine hang (model never asserts done): WAIT lasts exactly 15 cycles.
  - Required: rsp_err=1 with zero payload, then IDLE accepts the next request normally.
- Boundary cases:
  - eng_done on the 15th WAIT cycle gives a normal result with err=0.
  - A spurious eng_done in IDLE is ignored.
- rst asserted mid-WAIT:
  - Next cycle busy=0, state IDLE, pointer 0, no rsp_valid.
  - A subsequent request from 0 and 3 is granted to 0.
